// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, register-file typedefs and
// the write-data selector opcodes.
package pipe_pkg;

    localparam int DW_DEF = 32;  // register/data width
    localparam int AW_DEF = 5;   // register address width

    typedef logic [DW_DEF-1:0] word_t;
    typedef logic [AW_DEF-1:0] reg_addr_t;

    // Register 0 reads as zero and is never written.
    localparam reg_addr_t REG_ZERO = '0;

    // Write-data selector source codes.
    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC4 = 2'd2,
        WB_SEL_IMM = 2'd3
    } wb_sel_e;

endpackage

// File: rtl/rf_bypass.sv
// Combinational read-port mux: zero register, write-to-read bypass, then
// stored array data.
module rf_bypass #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic [AW-1:0] ra,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [DW-1:0] arr_d,
    output logic [DW-1:0] rd
);

    // Select read data for this port; register 0 wins over any bypass.
    always_comb begin
        // NOTE: rd gets a value on every path through this block, so no latch is inferred.
        rd = arr_d;
        if (ra == '0) begin
            rd = '0;
        end else if (we && (wa == ra)) begin
            rd = wd;
        end
    end

endmodule

// File: rtl/rf_wb_regfile.sv
// Architectural register file: 2**AW flop-based registers (r0 hardwired to
// zero), two bypassed decode read ports, a committed-state debug port and a
// committed-write counter.
import pipe_pkg::*;

module rf_wb_regfile #(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic [AW-1:0] dbg_a,
    output logic [DW-1:0] dbg_d,
    output logic [31:0]   wb_cnt
);

    localparam int NREG = 2 ** AW;

    // Register 0 has no storage; the array starts at index 1.
    logic [DW-1:0] regs_q [1:NREG-1];
    logic [DW-1:0] regs_d [1:NREG-1];
    logic [31:0]   wb_cnt_q;
    logic [31:0]   wb_cnt_d;
    logic          commit;

    logic [DW-1:0] arr1;
    logic [DW-1:0] arr2;

    assign commit = we && (wa != AW'(REG_ZERO));

    // Next-state of the array and the counter for a committing write.
    always_comb begin
        regs_d   = regs_q;
        wb_cnt_d = wb_cnt_q;
        if (commit) begin
            regs_d[wa] = wd;
            wb_cnt_d   = wb_cnt_q + 32'd1;
        end
    end

    // State update; reset has priority and drops any coincident write.
    always_ff @(posedge clk) begin
        // NOTE: the array is built from flops precisely so that every entry can be cleared in the single reset cycle.
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            wb_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
            regs_q   <= regs_d;
            wb_cnt_q <= wb_cnt_d;
        end
    end

    // Raw committed-state reads; address 0 never touches the array.
    always_comb begin
        arr1  = '0;
        arr2  = '0;
        dbg_d = '0;
        if (ra1 != '0)   arr1  = regs_q[ra1];
        if (ra2 != '0)   arr2  = regs_q[ra2];
        if (dbg_a != '0) dbg_d = regs_q[dbg_a];
    end

    rf_bypass #(.DW(DW), .AW(AW)) u_byp1 (
        .ra    (ra1),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .arr_d (arr1),
        .rd    (rd1)
    );

    rf_bypass #(.DW(DW), .AW(AW)) u_byp2 (
        .ra    (ra2),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .arr_d (arr2),
        .rd    (rd2)
    );

    assign wb_cnt = wb_cnt_q;

endmodule

// File: tb/tb_rf_wb_regfile.sv
// Self-checking bench for rf_wb_regfile: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against an
// array-based reference model.
module tb_rf_wb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] wa = '0;
    logic [DW-1:0] wd = '0;
    logic [AW-1:0] ra1 = '0;
    logic [AW-1:0] ra2 = '0;
    logic [AW-1:0] dbg_a = '0;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] dbg_d;
    logic [31:0]   wb_cnt;

    int checks = 0;
    int errors = 0;

    rf_wb_regfile #(.DW(DW), .AW(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .wa     (wa),
        .wd     (wd),
        .ra1    (ra1),
        .ra2    (ra2),
        .rd1    (rd1),
        .rd2    (rd2),
        .dbg_a  (dbg_a),
        .dbg_d  (dbg_d),
        .wb_cnt (wb_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW-1:0] m_regs [0:31];
    logic [31:0]   m_cnt;
    bit            m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= '0;
            m_cnt   <= '0;
            m_valid <= 1'b1;
        end else if (we && wa != 0) begin
            m_regs[wa] <= wd;
            m_cnt      <= m_cnt + 32'd1;
        end
    end

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (we && wa == a) return wd;
        return m_regs[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison once the model holds a known state.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_rd1", rd1, exp_rd(ra1));
            check("model_rd2", rd2, exp_rd(ra2));
            check("model_dbg", dbg_d, (dbg_a == 0) ? '0 : m_regs[dbg_a]);
            check("model_cnt", wb_cnt, m_cnt);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic [AW-1:0] dbg);
        we = w; wa = a; wd = d; ra1 = r1; ra2 = r2; dbg_a = dbg;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        // Initial reset.
        rst = 1'b1; drive(0, 0, 0, 0, 0, 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("reset_cnt", wb_cnt, 32'd0);
        check("reset_rd1", rd1, 32'd0);

        // Preload r1..r31 with nonzero values.
        for (int i = 1; i < 32; i++) begin
            next_cycle();
            drive(1, AW'(i), 32'hA500_0000 | 32'(i), 0, 0, 0);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 9);
        @(negedge clk);
        check("preload_dbg9", dbg_d, 32'hA500_0009);
        check("preload_cnt", wb_cnt, 32'd31);

        // Reset clear: all registers and the counter return to zero.
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int i = 1; i < 32; i++) begin
            drive(0, 0, 0, 0, 0, AW'(i));
            @(negedge clk);
            check("clear_dbg", dbg_d, 32'd0);
            next_cycle();
        end
        check("clear_cnt", wb_cnt, 32'd0);

        // Write then read: bypass in the same cycle, storage afterwards.
        drive(1, 5, 32'hDEADBEEF, 5, 0, 5);
        @(negedge clk);
        check("bypass_rd1", rd1, 32'hDEADBEEF);
        check("bypass_dbg_old", dbg_d, 32'd0);
        next_cycle();
        drive(0, 0, 0, 5, 0, 5);
        @(negedge clk);
        check("stored_rd1", rd1, 32'hDEADBEEF);
        check("stored_dbg", dbg_d, 32'hDEADBEEF);
        check("write_cnt", wb_cnt, 32'd1);

        // Dual bypass against an older stored value.
        next_cycle();
        drive(1, 7, 32'h55, 0, 0, 0);
        next_cycle();
        drive(1, 7, 32'h10, 7, 7, 7);
        @(negedge clk);
        check("dual_rd1", rd1, 32'h10);
        check("dual_rd2", rd2, 32'h10);
        check("dual_dbg_old", dbg_d, 32'h55);
        next_cycle();
        drive(0, 0, 0, 7, 7, 7);
        @(negedge clk);
        check("dual_dbg_new", dbg_d, 32'h10);
        check("dual_cnt", wb_cnt, 32'd3);

        // Register 0 writes are discarded and not counted.
        next_cycle();
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 0);
        @(negedge clk);
        check("r0_same", rd1, 32'd0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("r0_after", rd1, 32'd0);
        check("r0_cnt", wb_cnt, 32'd3);

        // Reset has priority over a coincident write.
        next_cycle();
        rst = 1'b1;
        drive(1, 3, 32'h12345678, 0, 0, 0);
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 0, 3, 0, 3);
        @(negedge clk);
        check("collide_rd1", rd1, 32'd0);
        check("collide_dbg", dbg_d, 32'd0);
        check("collide_cnt", wb_cnt, 32'd0);

        // Counter wrap, starting from a preset count.
        next_cycle();
        dut.wb_cnt_q = 32'hFFFFFFFE;
        m_cnt = 32'hFFFFFFFE;
        drive(1, 4, 32'h1, 0, 0, 0);
        next_cycle();
        check("wrap_ffffffff", wb_cnt, 32'hFFFFFFFF);
        drive(1, 4, 32'h2, 0, 0, 0);
        next_cycle();
        check("wrap_0", wb_cnt, 32'h0);
        drive(1, 4, 32'h3, 0, 0, 0);
        next_cycle();
        check("wrap_1", wb_cnt, 32'h1);
        drive(0, 0, 0, 0, 0, 0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 2000; n++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, 31));
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3) != 0, a, $urandom,
                  ($urandom_range(0, 2) == 0) ? a : AW'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0) ? a : AW'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? a : AW'($urandom_range(0, 31)));
            next_cycle();
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_regfile.md
# rf_wb_regfile

Architectural register file for the redirect pipeline. It sits directly downstream of the write-back data selector and consumes its 32-bit result. It holds the 32 general-purpose registers and serves the two decode-stage read ports. A write-to-read bypass makes same-cycle write-back data visible to decode without a pipeline bubble. A committed-write counter is provided for the performance display.

## Interface
Parameters:
- DW, 32, register/data width
- AW, 5, register address width (2**AW registers)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- we  in  1  write-back enable (RegWrite from MEM/WB)
- wa  in  AW  write-back destination register
- wd  in  DW  write-back data from the write-data selector
- ra1  in  AW  read address, port 1 (rs)
- ra2  in  AW  read address, port 2 (rt)
- rd1  out  DW  read data, port 1 (combinational)
- rd2  out  DW  read data, port 2 (combinational)
- dbg_a  in  AW  debug read address (display)
- dbg_d  out  DW  debug read data, no bypass
- wb_cnt  out  32  count of committed writes since reset

## Operation
- Storage: 2**AW registers of DW bits. Register 0 is hardwired to 0, never stored or counted.
- Commit: on a rising edge with we=1 and wa!=0, regs[wa] <= wd, and wb_cnt increments by 1.
- Writes with we=1, wa=0 are discarded. wb_cnt does not change. Writes with we=0 do nothing.
- Read port n, evaluated combinationally:
  - ra_n == 0 -> 0.
  - Otherwise, we=1 and wa == ra_n -> wd (bypass).
  - Otherwise -> regs[ra_n].
- Both ports may bypass the same write simultaneously.
- dbg_d = regs[dbg_a], with 0 for address 0. No bypass: it shows committed state only.
- wb_cnt wraps from 32'hFFFFFFFF to 0. There is no saturation.

## Timing
- Reset:
  - rst=1 at a rising edge clears every register and wb_cnt to 0.
  - rd1, rd2 and dbg_d therefore read 0 in the cycle after reset, unless a bypass applies.
  - rst has priority over we in the same cycle: the write is dropped and the counter is not incremented.
  - Reset mid-stream loses all state. No partial write survives.
- Write latency: 1 cycle to the array. Effective read-after-write latency is 0 cycles via the bypass.
  - Decode in cycle N sees a write presented in cycle N.
  - From cycle N+1 onward, decode reads the stored value.
- Back-to-back writes to the same register: the last edge wins. A read in each cycle returns that cycle's wd.
- Read outputs carry no registers. Combinational paths exist from ra1/ra2 to rd1/rd2 and from we/wa/wd to rd1/rd2. Upstream and downstream stages must not close a loop through them.
- The counter updates on the same edge as the array write.

## Structure
- Shared package `pipe_pkg`: DW and AW constants, register-0 index constant, and `reg_addr_t` / `word_t` typedefs. The opcode constants used by the write-data selector already live there.
- One sub-module is natural: `rf_bypass`, a pure combinational read-port mux (ra, we, wa, wd, array data -> rd). It is instantiated twice, once per read port.
- The storage array, write logic and counter stay in the top module. No memory macro is used; flops are required for single-cycle reset.

## Test plan
- Reset clear: preload regs 1..31 with nonzero values, pulse rst for 1 cycle -> all dbg_d reads 0, wb_cnt=0.
- Write then read: write 32'hDEADBEEF to r5 -> rd1 (ra1=5) shows 32'hDEADBEEF in the same cycle via bypass and on the next cycle from storage. wb_cnt increments to 1.
- Dual bypass: write 32'h00000010 to r7 while ra1=ra2=7 -> both rd1 and rd2 read 32'h00000010. dbg_d with dbg_a=7 reads the old value until the next cycle.
- Register 0: we=1, wa=0, wd=32'hFFFFFFFF -> rd1 (ra1=0) reads 0 in the same cycle and afterward. wb_cnt is unchanged.
- Reset vs write collision: rst=1 with we=1, wa=3, wd=32'h12345678 -> r3 reads 0 afterward, wb_cnt=0.
- Counter wrap: force wb_cnt near 32'hFFFFFFFE, perform 3 valid writes -> counts read FFFFFFFF, 0, 1.
